writeback_regfile: RTL and testbench

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/writeback_regfile.sv | 108 ++++++++++
 tb/tb_writeback_regfile.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// Write-back stage register file: 15 x 64-bit registers with two combinational read
// ports, architectural status tracking with a sticky halt, and retire/cycle counters.
module writeback_regfile #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       W_stat,
    input  logic [3:0]       W_icode,
    input  logic [63:0]      W_valE,
    input  logic [63:0]      W_valM,
    input  logic [3:0]       W_dstE,
    input  logic [3:0]       W_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [63:0]      d_rvalA,
    output logic [63:0]      d_rvalB,
    output logic [2:0]       Stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] ICODE_NOP = 4'h1;

    logic [63:0]      regs_r [0:14];
    logic [2:0]       stat_r;
    logic             halted_r;
    logic [CNT_W-1:0] retired_r;
    logic [CNT_W-1:0] cycles_r;

    logic             wr_en_s;
    logic             halt_s;
    logic             retire_s;
    logic [2:0]       stat_next_s;

    // Decode the write-back status into write, halt and retire qualifiers.
    always_comb begin
        wr_en_s     = 1'b0;
        halt_s      = 1'b0;
        retire_s    = 1'b0;
        stat_next_s = STAT_AOK;
        case (W_stat)
            STAT_HLT, STAT_ADR, STAT_INS: stat_next_s = W_stat;
            default:                      stat_next_s = STAT_AOK;
        endcase
        if (!halted_r) begin
            wr_en_s  = (W_stat == STAT_AOK);
            halt_s   = (stat_next_s != STAT_AOK);
            // HLT counts as retired; faulting ADR/INS instructions do not.
            retire_s = ((W_stat == STAT_AOK) && (W_icode != ICODE_NOP)) || (W_stat == STAT_HLT);
        end else begin
            wr_en_s  = 1'b0;
            halt_s   = 1'b0;
            retire_s = 1'b0;
        end
    end

    // Architectural state: registers, status, sticky halt and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs_r[i] <= 64'd0;
            end
            stat_r    <= STAT_AOK;
            halted_r  <= 1'b0;
            retired_r <= '0;
            cycles_r  <= '0;
        end else if (!halted_r) begin
            stat_r   <= stat_next_s;
            halted_r <= halt_s;
            cycles_r <= cycles_r + CNT_W'(1);
            if (retire_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end
            // M port is written last so it wins when both ports target the same register.
            if (wr_en_s && (W_dstE != REG_NONE)) begin
                regs_r[W_dstE] <= W_valE;
            end
            if (wr_en_s && (W_dstM != REG_NONE)) begin
                regs_r[W_dstM] <= W_valM;
            end
        end
    end

    // Combinational read ports straight from storage; index 0xF reads zero.
    always_comb begin
        if (d_srcA == REG_NONE) begin
            d_rvalA = 64'd0;
        end else begin
            d_rvalA = regs_r[d_srcA];
        end
        if (d_srcB == REG_NONE) begin
            d_rvalB = 64'd0;
        end else begin
            d_rvalB = regs_r[d_srcB];
        end
    end

    assign Stat    = stat_r;
    assign halted  = halted_r;
    assign retired = retired_r;
    assign cycles  = cycles_r;
endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: a 32-bit and a 4-bit counter instance share
// stimulus; a reference model pushes expected state and a monitor compares each cycle.
module tb_writeback_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  W_dstE, W_dstM, d_srcA, d_srcB;

    logic [63:0] rvalA, rvalB, rvalA4, rvalB4;
    logic [2:0]  stat, stat4;
    logic        halted, halted4;
    logic [31:0] retired, cycles;
    logic [3:0]  retired4, cycles4;

    always #5 clk = ~clk;

    writeback_regfile #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .W_stat(W_stat), .W_icode(W_icode),
        .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(rvalA), .d_rvalB(rvalB),
        .Stat(stat), .halted(halted), .retired(retired), .cycles(cycles)
    );

    writeback_regfile #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .W_stat(W_stat), .W_icode(W_icode),
        .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(rvalA4), .d_rvalB(rvalB4),
        .Stat(stat4), .halted(halted4), .retired(retired4), .cycles(cycles4)
    );

    typedef struct {
        logic [2:0]  stat;
        logic        halted;
        logic [31:0] ret;
        logic [31:0] cyc;
        logic [63:0] a;
        logic [63:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: architectural state as plain variables.
    logic [63:0] m_regs [16];
    logic [2:0]  m_stat;
    logic        m_halted;
    logic [31:0] m_ret;
    logic [31:0] m_cyc;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, want);
        end
    endtask

    // Monitor: every cycle where an expectation is queued, compare both instances.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stat",     {61'd0, stat},    {61'd0, e.stat});
            chk("halted",   {63'd0, halted},  {63'd0, e.halted});
            chk("retired",  {32'd0, retired}, {32'd0, e.ret});
            chk("cycles",   {32'd0, cycles},  {32'd0, e.cyc});
            chk("rvalA",    rvalA, e.a);
            chk("rvalB",    rvalB, e.b);
            chk("retired4", {60'd0, retired4}, {60'd0, e.ret[3:0]});
            chk("cycles4",  {60'd0, cycles4},  {60'd0, e.cyc[3:0]});
            chk("stat4",    {61'd0, stat4},    {61'd0, e.stat});
            chk("rvalA4",   rvalA4, e.a);
        end
    end

    task automatic step(input logic r, input logic [2:0] st, input logic [3:0] ic,
                        input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm,
                        input logic [3:0] sa, input logic [3:0] sb);
        exp_t e;
        @(negedge clk);
        rst = r; W_stat = st; W_icode = ic; W_dstE = de; W_valE = ve;
        W_dstM = dm; W_valM = vm; d_srcA = sa; d_srcB = sb;
        if (r) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
            m_stat = 3'd1; m_halted = 1'b0; m_ret = 32'd0; m_cyc = 32'd0;
        end else if (!m_halted) begin
            m_cyc = m_cyc + 32'd1;
            if (st == 3'd2 || st == 3'd3 || st == 3'd4) begin
                m_stat = st;
                m_halted = 1'b1;
                if (st == 3'd2) m_ret = m_ret + 32'd1;
            end else begin
                m_stat = 3'd1;
                if (st == 3'd1) begin
                    if (de != 4'hF) m_regs[de] = ve;
                    if (dm != 4'hF) m_regs[dm] = vm;
                    if (ic != 4'h1) m_ret = m_ret + 32'd1;
                end
            end
        end
        e.stat = m_stat; e.halted = m_halted; e.ret = m_ret; e.cyc = m_cyc;
        e.a = m_regs[sa]; e.b = m_regs[sb];
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] sa);
        step(1'b0, st, ic, 4'hF, 64'd0, 4'hF, 64'd0, sa, 4'hF);
    endtask

    initial begin
        logic [2:0] st;
        int unsigned p;
        for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
        m_stat = 3'd1; m_halted = 1'b0; m_ret = 32'd0; m_cyc = 32'd0;
        rst = 1'b1; W_stat = 3'd1; W_icode = 4'h1; W_valE = 64'd0; W_valM = 64'd0;
        W_dstE = 4'hF; W_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;

        // Basic write and visibility after the edge.
        step(1'b1, 3'd1, 4'h3, 4'h2, 64'h55, 4'hF, 64'd0, 4'h2, 4'h0);
        step(1'b0, 3'd1, 4'h3, 4'h2, 64'h1234, 4'hF, 64'd0, 4'h2, 4'hF);
        // Same destination on both ports: M wins.
        step(1'b0, 3'd1, 4'hB, 4'h4, 64'h10, 4'h4, 64'h20, 4'h4, 4'h2);
        // HLT: no write, retires, freezes everything.
        step(1'b0, 3'd2, 4'h0, 4'h0, 64'hFF, 4'h0, 64'hEE, 4'h0, 4'h4);
        step(1'b0, 3'd1, 4'h3, 4'h0, 64'h77, 4'h5, 64'h88, 4'h0, 4'h5);
        idle(3'd4, 4'h3, 4'h4);
        // INS after reset: does not retire; reset clears registers.
        step(1'b1, 3'd1, 4'h3, 4'h4, 64'h99, 4'hF, 64'd0, 4'h4, 4'h2);
        step(1'b0, 3'd1, 4'h3, 4'h6, 64'hABCD, 4'hF, 64'd0, 4'h6, 4'hF);
        step(1'b0, 3'd4, 4'h3, 4'h6, 64'h1, 4'hF, 64'd0, 4'h6, 4'hF);
        step(1'b1, 3'd1, 4'h1, 4'hF, 64'd0, 4'hF, 64'd0, 4'h6, 4'h2);
        // Five bubbles: cycles counts, retired does not; 0xF reads zero.
        for (int i = 0; i < 5; i++) idle(3'd1, 4'h1, 4'hF);
        // Bubble/unknown status codes behave as AOK without writing.
        step(1'b0, 3'd0, 4'h3, 4'h1, 64'h5, 4'hF, 64'd0, 4'h1, 4'hF);
        step(1'b0, 3'd6, 4'h3, 4'h1, 64'h5, 4'hF, 64'd0, 4'h1, 4'hF);
        // Wrap the 4-bit counters.
        step(1'b1, 3'd1, 4'h1, 4'hF, 64'd0, 4'hF, 64'd0, 4'hF, 4'hF);
        for (int i = 0; i < 17; i++) idle(3'd1, 4'h3, 4'hF);

        // Randomized traffic with occasional halts and resets.
        for (int n = 0; n < 3000; n++) begin
            p = $urandom_range(0, 99);
            if (p < 86)      st = 3'd1;
            else if (p < 92) st = 3'($urandom_range(5, 7)) & 3'b111;
            else if (p < 94) st = 3'd0;
            else             st = 3'($urandom_range(2, 4));
            step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0, st,
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), {$urandom, $urandom},
                 4'($urandom_range(0, 15)), {$urandom, $urandom},
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
